// File: rtl/wb_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_unit
// Description : Write-back stage. Arbitrates ALU results and buffered LSU
//               results onto one registered register-file write port and
//               tracks pending writes for RAW hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_unit #(
    parameter int XLEN           = 32,
    parameter int REG_IDX_WIDTH  = 5,
    parameter int LSU_FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid_i,
    output logic                     alu_ready_o,
    input  logic [REG_IDX_WIDTH-1:0] alu_rd_idx_i,
    input  logic [XLEN-1:0]          alu_rd_wdata_i,
    input  logic                     lsu_valid_i,
    output logic                     lsu_ready_o,
    input  logic [REG_IDX_WIDTH-1:0] lsu_rd_idx_i,
    input  logic [XLEN-1:0]          lsu_rd_wdata_i,
    input  logic                     issue_en_i,
    input  logic [REG_IDX_WIDTH-1:0] issue_rd_idx_i,
    input  logic [REG_IDX_WIDTH-1:0] rs1_idx_i,
    input  logic [REG_IDX_WIDTH-1:0] rs2_idx_i,
    output logic                     rs1_busy_o,
    output logic                     rs2_busy_o,
    output logic                     rd_en_o,
    output logic [REG_IDX_WIDTH-1:0] rd_idx_o,
    output logic [XLEN-1:0]          rd_wdata_o
);

    localparam int c_PTR_W = $clog2(LSU_FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_NREG  = 1 << REG_IDX_WIDTH;
    localparam int c_LAST  = LSU_FIFO_DEPTH - 1;

    logic [REG_IDX_WIDTH-1:0] r_fifo_idx  [LSU_FIFO_DEPTH];
    logic [XLEN-1:0]          r_fifo_data [LSU_FIFO_DEPTH];
    logic [c_PTR_W-1:0]       r_wptr;
    logic [c_PTR_W-1:0]       r_rptr;
    logic [c_CNT_W-1:0]       r_count;
    logic [c_NREG-1:0]        r_busy;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_sel;
    logic [REG_IDX_WIDTH-1:0] w_sel_idx;
    logic [XLEN-1:0]          w_sel_data;
    logic [c_NREG-1:0]        w_set_mask;
    logic [c_NREG-1:0]        w_clr_mask;

    function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(c_LAST)) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends on occupancy only, so a same-cycle pop never frees a slot.
    assign w_full      = (r_count == c_CNT_W'(LSU_FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign alu_ready_o = ~rst & ~w_full;
    assign lsu_ready_o = ~rst & ~w_full;
    assign w_push      = lsu_valid_i & lsu_ready_o;

    always_comb begin
        w_pop      = 1'b0;
        w_sel      = 1'b0;
        w_sel_idx  = alu_rd_idx_i;
        w_sel_data = alu_rd_wdata_i;
        if (w_full) begin
            w_pop      = 1'b1;
            w_sel      = 1'b1;
            w_sel_idx  = r_fifo_idx[r_rptr];
            w_sel_data = r_fifo_data[r_rptr];
        end else if (alu_valid_i) begin
            w_sel      = 1'b1;
        end else if (!w_empty) begin
            w_pop      = 1'b1;
            w_sel      = 1'b1;
            w_sel_idx  = r_fifo_idx[r_rptr];
            w_sel_data = r_fifo_data[r_rptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= f_inc(r_wptr);
            if (w_pop)  r_rptr <= f_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wptr]  <= lsu_rd_idx_i;
            r_fifo_data[r_wptr] <= lsu_rd_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_o    <= 1'b0;
            rd_idx_o   <= '0;
            rd_wdata_o <= '0;
        end else begin
            rd_en_o <= w_sel & (w_sel_idx != '0);
            if (w_sel) begin
                rd_idx_o   <= w_sel_idx;
                rd_wdata_o <= w_sel_data;
            end
        end
    end

    // Set is applied after clear so a re-issue on the retiring edge stays busy.
    assign w_set_mask = (issue_en_i && issue_rd_idx_i != '0)
                      ? (c_NREG'(1) << issue_rd_idx_i) : '0;
    assign w_clr_mask = rd_en_o ? (c_NREG'(1) << rd_idx_o) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~c_NREG'(1);
        end
    end

    assign rs1_busy_o = r_busy[rs1_idx_i];
    assign rs2_busy_o = r_busy[rs2_idx_i];

endmodule
`default_nettype wire

// File: tb/tb_wb_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb_unit
// Description : Self-checking bench for wb_unit: directed vector table,
//               mid-stream reset sequence and randomized traffic vs. a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_unit;

    localparam int XLEN  = 32;
    localparam int RIW   = 5;
    localparam int DEPTH = 2;
    localparam int NREG  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid_i, alu_ready_o;
    logic [RIW-1:0]  alu_rd_idx_i;
    logic [XLEN-1:0] alu_rd_wdata_i;
    logic            lsu_valid_i, lsu_ready_o;
    logic [RIW-1:0]  lsu_rd_idx_i;
    logic [XLEN-1:0] lsu_rd_wdata_i;
    logic            issue_en_i;
    logic [RIW-1:0]  issue_rd_idx_i, rs1_idx_i, rs2_idx_i;
    logic            rs1_busy_o, rs2_busy_o;
    logic            rd_en_o;
    logic [RIW-1:0]  rd_idx_o;
    logic [XLEN-1:0] rd_wdata_o;

    wb_unit #(.XLEN(XLEN), .REG_IDX_WIDTH(RIW), .LSU_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_rd_idx_i(alu_rd_idx_i), .alu_rd_wdata_i(alu_rd_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_rd_idx_i(lsu_rd_idx_i), .lsu_rd_wdata_i(lsu_rd_wdata_i),
        .issue_en_i(issue_en_i), .issue_rd_idx_i(issue_rd_idx_i),
        .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .rd_en_o(rd_en_o), .rd_idx_o(rd_idx_o), .rd_wdata_o(rd_wdata_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue for the LSU buffer, a busy flag per register,
    // and the expected contents of the write port.
    typedef struct packed {
        logic [RIW-1:0]  idx;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q[$];
    bit              mbusy[NREG];
    logic            m_en;
    logic [RIW-1:0]  m_idx;
    logic [XLEN-1:0] m_data;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NREG; i++) mbusy[i] = 1'b0;
        m_en   = 1'b0;
        m_idx  = '0;
        m_data = '0;
    endtask

    task automatic drive(input logic av, input logic [RIW-1:0] aidx, input logic [31:0] adata,
                         input logic lv, input logic [RIW-1:0] lidx, input logic [31:0] ldata,
                         input logic ie, input logic [RIW-1:0] iidx,
                         input logic [RIW-1:0] r1, input logic [RIW-1:0] r2);
        alu_valid_i = av; alu_rd_idx_i = aidx; alu_rd_wdata_i = adata;
        lsu_valid_i = lv; lsu_rd_idx_i = lidx; lsu_rd_wdata_i = ldata;
        issue_en_i  = ie; issue_rd_idx_i = iidx;
        rs1_idx_i   = r1; rs2_idx_i = r2;
    endtask

    // Called mid-cycle: checks combinational outputs, advances one edge,
    // then checks the registered write port.
    task automatic step();
        bit   full, have;
        ent_t s;
        chk("alu_ready", alu_ready_o, (q.size() < DEPTH));
        chk("lsu_ready", lsu_ready_o, (q.size() < DEPTH));
        chk("rs1_busy", rs1_busy_o, mbusy[rs1_idx_i]);
        chk("rs2_busy", rs2_busy_o, mbusy[rs2_idx_i]);
        @(posedge clk);
        full = (q.size() == DEPTH);
        have = 1'b0;
        if (full) begin
            s = q.pop_front(); have = 1'b1;
        end else if (alu_valid_i) begin
            s = '{alu_rd_idx_i, alu_rd_wdata_i}; have = 1'b1;
        end else if (q.size() > 0) begin
            s = q.pop_front(); have = 1'b1;
        end
        if (lsu_valid_i && !full) q.push_back('{lsu_rd_idx_i, lsu_rd_wdata_i});
        if (m_en) mbusy[m_idx] = 1'b0;
        if (issue_en_i && issue_rd_idx_i != 0) mbusy[issue_rd_idx_i] = 1'b1;
        if (have) begin
            m_en = (s.idx != 0); m_idx = s.idx; m_data = s.data;
        end else begin
            m_en = 1'b0;
        end
        #1;
        chk("rd_en", rd_en_o, m_en);
        chk("rd_idx", rd_idx_o, m_idx);
        chk("rd_wdata", rd_wdata_o, m_data);
    endtask

    typedef struct {
        logic av; logic [RIW-1:0] aidx; logic [31:0] adata;
        logic lv; logic [RIW-1:0] lidx; logic [31:0] ldata;
        logic ie; logic [RIW-1:0] iidx; logic [RIW-1:0] rs;
        logic e_ar; logic e_lr; logic e_busy;
        logic e_en; logic [RIW-1:0] e_idx; logic [31:0] e_data;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic av, input logic [RIW-1:0] aidx, input logic [31:0] adata,
                       input logic lv, input logic [RIW-1:0] lidx, input logic [31:0] ldata,
                       input logic ie, input logic [RIW-1:0] iidx, input logic [RIW-1:0] rs,
                       input logic e_ar, input logic e_lr, input logic e_busy,
                       input logic e_en, input logic [RIW-1:0] e_idx, input logic [31:0] e_data);
        vec_t v;
        v = '{av, aidx, adata, lv, lidx, ldata, ie, iidx, rs, e_ar, e_lr, e_busy, e_en, e_idx, e_data};
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset rd_en", rd_en_o, 1'b0);
        chk("reset rd_idx", rd_idx_o, '0);
        chk("reset rd_wdata", rd_wdata_o, '0);

        //   av idx data        lv idx data   ie idx rs  ar lr busy en idx data
        add(0, 0, 0,            0, 0, 0,      1, 5, 5,   1, 1, 0,   0, 0, 32'h0);
        add(1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 5,   1, 1, 1,   1, 5, 32'hDEADBEEF);
        add(0, 0, 0,            0, 0, 0,      0, 0, 5,   1, 1, 1,   0, 5, 32'hDEADBEEF);
        add(0, 0, 0,            0, 0, 0,      0, 0, 5,   1, 1, 0,   0, 5, 32'hDEADBEEF);
        add(1, 0, 32'h1,        0, 0, 0,      1, 0, 0,   1, 1, 0,   0, 0, 32'h1);
        add(0, 0, 0,            0, 0, 0,      0, 0, 0,   1, 1, 0,   0, 0, 32'h1);
        add(1, 1, 32'h11,       1, 7, 32'h77, 0, 0, 0,   1, 1, 0,   1, 1, 32'h11);
        add(1, 2, 32'h22,       1, 8, 32'h88, 0, 0, 0,   1, 1, 0,   1, 2, 32'h22);
        add(1, 3, 32'h33,       0, 0, 0,      0, 0, 0,   0, 0, 0,   1, 7, 32'h77);
        add(1, 3, 32'h33,       0, 0, 0,      0, 0, 0,   1, 1, 0,   1, 3, 32'h33);
        add(0, 0, 0,            0, 0, 0,      0, 0, 0,   1, 1, 0,   1, 8, 32'h88);
        add(0, 0, 0,            1, 9, 32'h99, 0, 0, 0,   1, 1, 0,   0, 8, 32'h88);
        add(0, 0, 0,            1, 10,32'hAA, 0, 0, 0,   1, 1, 0,   1, 9, 32'h99);
        add(0, 0, 0,            0, 0, 0,      0, 0, 0,   1, 1, 0,   1, 10,32'hAA);
        add(0, 0, 0,            0, 0, 0,      0, 0, 0,   1, 1, 0,   0, 10,32'hAA);
        add(1, 4, 32'h44,       1, 11,32'hB1, 0, 0, 0,   1, 1, 0,   1, 4, 32'h44);
        add(1, 4, 32'h45,       1, 12,32'hB2, 0, 0, 0,   1, 1, 0,   1, 4, 32'h45);
        add(1, 6, 32'h46,       1, 13,32'hB3, 0, 0, 0,   0, 0, 0,   1, 11,32'hB1);
        add(0, 0, 0,            0, 0, 0,      0, 0, 0,   1, 1, 0,   1, 12,32'hB2);
        add(0, 0, 0,            0, 0, 0,      0, 0, 0,   1, 1, 0,   0, 12,32'hB2);
        add(0, 0, 0,            0, 0, 0,      1, 3, 3,   1, 1, 0,   0, 12,32'hB2);
        add(1, 3, 32'h333,      0, 0, 0,      0, 0, 3,   1, 1, 1,   1, 3, 32'h333);
        add(0, 0, 0,            0, 0, 0,      1, 3, 3,   1, 1, 1,   0, 3, 32'h333);
        add(0, 0, 0,            0, 0, 0,      0, 0, 3,   1, 1, 1,   0, 3, 32'h333);

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].aidx, tbl[i].adata, tbl[i].lv, tbl[i].lidx, tbl[i].ldata,
                  tbl[i].ie, tbl[i].iidx, tbl[i].rs, tbl[i].rs);
            #3;
            chk($sformatf("vec%0d alu_ready", i), alu_ready_o, tbl[i].e_ar);
            chk($sformatf("vec%0d lsu_ready", i), lsu_ready_o, tbl[i].e_lr);
            chk($sformatf("vec%0d rs1_busy", i), rs1_busy_o, tbl[i].e_busy);
            step();
            chk($sformatf("vec%0d rd_en", i), rd_en_o, tbl[i].e_en);
            chk($sformatf("vec%0d rd_idx", i), rd_idx_o, tbl[i].e_idx);
            chk($sformatf("vec%0d rd_wdata", i), rd_wdata_o, tbl[i].e_data);
        end

        // Mid-stream reset with two loads buffered and a write in flight.
        drive(1, 20, 32'hA0, 1, 21, 32'hC1, 1, 9, 9, 0);
        #3 step();
        drive(1, 22, 32'hA1, 1, 23, 32'hC2, 0, 0, 9, 0);
        #3 step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst rd_en", rd_en_o, 1'b0);
        chk("rst rd_idx", rd_idx_o, '0);
        chk("rst rd_wdata", rd_wdata_o, '0);
        chk("rst alu_ready", alu_ready_o, 1'b0);
        chk("rst lsu_ready", lsu_ready_o, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        repeat (4) begin
            #3 step();
        end
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            rs1_idx_i = RIW'(i);
            #1 chk($sformatf("post-rst busy x%0d", i), rs1_busy_o, 1'b0);
        end
        @(posedge clk); #1;

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 1), RIW'($urandom_range(0, 9)), $urandom,
                  $urandom_range(0, 1), RIW'($urandom_range(0, 9)), $urandom,
                  ($urandom_range(0, 3) == 0), RIW'($urandom_range(0, 9)),
                  RIW'($urandom_range(0, 9)), RIW'($urandom_range(0, 9)));
            #3 step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Write-back stage: the writer side of the integer register file.
- Collects completed results from the single-cycle ALU path and the multi-cycle LSU path, and buffers LSU results in a small FIFO.
- Arbitrates one write per cycle and drives a registered write port (rd_en/rd_idx/rd_wdata) into the register file.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards on rs1/rs2.

Parameters:
XLEN, 32, data width
REG_IDX_WIDTH, 5, register index width (2**REG_IDX_WIDTH registers)
LSU_FIFO_DEPTH, 2, LSU result buffer entries (>= 2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
alu_valid_i  in  1  ALU result valid
alu_ready_o  out  1  ALU result accepted this cycle when valid & ready
alu_rd_idx_i  in  REG_IDX_WIDTH  ALU destination
alu_rd_wdata_i  in  XLEN  ALU result
lsu_valid_i  in  1  load result valid
lsu_ready_o  out  1  FIFO can accept
lsu_rd_idx_i  in  REG_IDX_WIDTH  load destination
lsu_rd_wdata_i  in  XLEN  load data
issue_en_i  in  1  decode issued an instruction that writes rd
issue_rd_idx_i  in  REG_IDX_WIDTH  issued destination
rs1_idx_i  in  REG_IDX_WIDTH  decode source 1 query
rs2_idx_i  in  REG_IDX_WIDTH  decode source 2 query
rs1_busy_o  out  1  rs1 has a pending write
rs2_busy_o  out  1  rs2 has a pending write
rd_en_o  out  1  register file write enable (registered)
rd_idx_o  out  REG_IDX_WIDTH  write index (registered)
rd_wdata_o  out  XLEN  write data (registered)

Behaviour:
- Reset (async, immediate):
  - rd_en_o=0, rd_idx_o=0, rd_wdata_o=0.
  - FIFO emptied (pointers and count = 0); all scoreboard bits cleared.
  - alu_ready_o and lsu_ready_o forced 0 while rst=1.
  - Reset mid-operation silently drops buffered and in-flight results.
- LSU FIFO:
  - Count width clog2(DEPTH)+1.
  - Read and write pointers wrap from DEPTH-1 to 0.
  - lsu_ready_o = ~full, derived from count only; it does not depend on a same-cycle pop.
  - Push when lsu_valid_i & lsu_ready_o.
  - Push and pop in the same cycle leaves count unchanged.
  - Data is never lost or duplicated.
- Arbitration (combinational select, one winner per cycle):
  - 1. FIFO full: select FIFO head, pop; alu_ready_o=0.
  - 2. Else if alu_valid_i: select ALU; alu_ready_o=1.
  - 3. Else if FIFO non-empty: select FIFO head, pop.
  - 4. Else: nothing selected.
  - alu_ready_o = ~full regardless of alu_valid_i.
- Output register, loaded every cycle:
  - rd_en_o <= selected & (selected idx != 0).
  - rd_idx_o and rd_wdata_o load the selected idx/data when selected; otherwise they hold.
  - Index 0 results are consumed (popped/acked) but never produce rd_en_o.
- Latency:
  - ALU accepted at edge N -> rd_en_o high in cycle N+1.
  - LSU accepted at edge N (pushed) -> earliest rd_en_o in cycle N+2.
  - The register file commits on the edge ending the rd_en_o cycle.
- Scoreboard busy[2**REG_IDX_WIDTH-1:1]:
  - Set on issue_en_i for issue_rd_idx_i != 0.
  - Cleared at the edge where rd_en_o=1 for rd_idx_o.
  - Same index set and cleared on the same edge: set wins.
  - Index 0 is never busy.
  - rsX_busy_o = busy[rsX_idx_i], combinational, no bypass; busy drops the cycle after the rd_en_o cycle.
- Ordering:
  - FIFO preserves LSU order.
  - ALU and LSU results to the same rd are not reordered by this block; decode must not issue a second writer to a busy rd.

Test Plan:
- Reset: assert rst mid-stream with 2 LSU entries buffered -> rd_en_o=0 immediately, lsu_ready_o=1 after release, no buffered write appears, rs1_busy_o=0 for all idx.
- ALU only: alu_valid_i=1, idx=5, data=0xDEADBEEF at edge N -> cycle N+1 rd_en_o=1, rd_idx_o=5, rd_wdata_o=0xDEADBEEF; with issue of x5 beforehand, rs1_idx_i=5 busy until cycle N+2.
- LSU starvation: hold alu_valid_i=1 every cycle, push loads idx 7 and 8 -> FIFO fills, alu_ready_o=0 for one cycle, rd_idx_o=7 written, next cycle ALU resumes, idx 8 then drains when full again or when ALU idles; order 7 before 8.
- Full boundary: DEPTH=2, push while full -> lsu_ready_o=0, no push; push and pop in the same cycle at count=1 -> count stays 1, data order preserved.
- x0 target: ALU idx=0 data=0x1 -> alu_ready_o=1, rd_en_o stays 0; issue_en_i with idx 0 -> rs1_busy_o=0 for rs1_idx_i=0.
- Set/clear collision: x3 busy, rd_en_o=1 idx 3 while issue_en_i idx 3 -> busy[3] remains 1 after the edge.
